cardinal_nic: RTL and testbench
===============================

Name: cardinal_nic

Overview:
Network interface controller on the far side of the processor's NIC port. It responds to processor register reads and writes on a 2-bit address bus. It buffers packets arriving from the router into an input FIFO and packets written by the processor into an output FIFO. It drives a send/ready handshake on the router link in both directions.

Parameters:
DATA_W, 64, packet and processor data width
IN_DEPTH, 2, input FIFO entries (power of two, >=2)
OUT_DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
addr  input  2  [0:1] register select from processor
d_in  input  DATA_W  [0:63] processor write data
d_out  output  DATA_W  [0:63] registered processor read data
nicEn  input  1  access strobe, one cycle per access
nicWrEn  input  1  1=write, 0=read; valid with nicEn
net_si  input  1  router offers packet to NIC
net_ri  output  1  NIC can accept packet from router
net_di  input  DATA_W  [0:63] packet from router
net_so  output  1  NIC offers packet to router
net_ro  input  1  router can accept packet
net_do  output  DATA_W  [0:63] packet to router

Behaviour:
- Reset: both FIFOs empty (read/write pointers and counts = 0); d_out=0; net_so=0; net_ri=0 while reset is high. Reset mid-transfer discards all buffered packets.
- Register map, bit 63 = LSB:
  - 00: input FIFO head. Read only.
  - 01: input status. Read only. Bit 63 = input FIFO non-empty; other bits 0.
  - 10: output FIFO tail. Write only. Read returns 0.
  - 11: output status. Read only. Bit 63 = output FIFO full; other bits 0.
  - Writes to 00, 01 and 11 are ignored.
- Read latency is 1 cycle. The NIC samples nicEn=1, nicWrEn=0 at edge N and loads d_out at that edge, so the value is valid in the cycle after the strobe. d_out holds until the next read.
- Read 00 when non-empty: d_out=head and the head pops at the same edge.
- Read 00 when empty: d_out=current storage at the read pointer (stale data); no pointer or count change.
- Write 10 with the output FIFO not full at the edge: push d_in. Write when full: silently dropped, no state change.
- Input side: net_ri = ~reset & (in_count != IN_DEPTH), combinational from state. A push of net_di occurs at an edge where net_si & net_ri. net_si while net_ri=0 is ignored; the router holds the packet.
- Output side: net_so = (out_count != 0), net_do = output head, both combinational from state. A pop occurs at an edge where net_so & net_ro.
- Simultaneous push and pop on the same FIFO in one cycle: both happen and the count is unchanged.
  - A processor write when full with a same-cycle router pop is still dropped, because fullness is sampled before the edge.
  - A router push into a full input FIFO with a same-cycle processor read is blocked, because net_ri=0.
- Pointers wrap modulo depth. Counts range 0..DEPTH; the count width holds DEPTH.
- nicWrEn is ignored when nicEn=0. No access has any side effect beyond those listed.

Test Plan:
- Reset, then idle: d_out=0, net_so=0, net_ri=1 one cycle after reset deasserts; read 01 -> d_out=0; read 11 -> d_out=0.
- Router sends 0xAAAA_0000_0000_0001 (net_si=1 one cycle) -> read 01 gives bit63=1; read 00 next cycle gives d_out=0xAAAA_0000_0000_0001; read 01 then gives 0.
- Router sends 3 packets back-to-back, IN_DEPTH=2 -> net_ri drops after the 2nd push and the 3rd is held. One processor read of 00 -> net_ri=1, the 3rd packet is accepted, and FIFO order is preserved.
- Processor writes 10 with 0x1, 0x2, then 0x3, with net_ro=0 -> status 11 bit63=1 after the 2nd write, 0x3 dropped. Raise net_ro -> net_do=0x1 then 0x2 on consecutive cycles, net_so=0 afterwards.
- Output full with net_ro=1 and a processor write of 0x9 in the same cycle -> 0x9 dropped, count goes 2->1.
- Reset asserted with both FIFOs holding 1 entry -> next cycle net_so=0, status registers read 0, d_out=0.

Source files
------------

// File: rtl/cardinal_nic.sv
`timescale 1ns/1ps
// Processor-side NIC: a 4-entry register map over an input FIFO (router -> CPU)
// and an output FIFO (CPU -> router), with send/ready handshakes on both links.
module cardinal_nic #(
    parameter int DATA_W    = 64,
    parameter int IN_DEPTH  = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);

    localparam logic [0:1] A_IN_DATA  = 2'b00;
    localparam logic [0:1] A_IN_STAT  = 2'b01;
    localparam logic [0:1] A_OUT_DATA = 2'b10;
    localparam logic [0:1] A_OUT_STAT = 2'b11;

    logic [0:DATA_W-1] r_in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  r_in_rd;
    logic [IN_AW-1:0]  r_in_wr;
    logic [IN_CW-1:0]  r_in_cnt;

    logic [0:DATA_W-1] r_out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] r_out_rd;
    logic [OUT_AW-1:0] r_out_wr;
    logic [OUT_CW-1:0] r_out_cnt;

    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_in_empty;
    logic              w_in_full;
    logic              w_in_push;
    logic              w_in_pop;
    logic              w_out_empty;
    logic              w_out_full;
    logic              w_out_push;
    logic              w_out_pop;
    logic [0:DATA_W-1] w_in_stat;
    logic [0:DATA_W-1] w_out_stat;

    assign w_rd_req    = nicEn & ~nicWrEn;
    assign w_wr_req    = nicEn & nicWrEn;

    assign w_in_empty  = (r_in_cnt == '0);
    assign w_in_full   = (r_in_cnt == IN_FULL);
    assign w_out_empty = (r_out_cnt == '0);
    assign w_out_full  = (r_out_cnt == OUT_FULL);

    // Fullness/emptiness are taken from pre-edge state, so a same-cycle pop
    // never makes room for a push on that edge.
    assign w_in_push   = net_si & net_ri;
    assign w_in_pop    = w_rd_req & (addr == A_IN_DATA) & ~w_in_empty;
    assign w_out_push  = w_wr_req & (addr == A_OUT_DATA) & ~w_out_full;
    assign w_out_pop   = net_so & net_ro;

    assign net_ri      = ~reset & ~w_in_full;
    assign net_so      = ~w_out_empty;
    assign net_do      = r_out_mem[r_out_rd];

    // Status flags live in bit DATA_W-1, the LSB of the ascending vector.
    assign w_in_stat   = {{(DATA_W-1){1'b0}}, ~w_in_empty};
    assign w_out_stat  = {{(DATA_W-1){1'b0}}, w_out_full};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_rd  <= '0;
            r_in_wr  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
            if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
                2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wr] <= net_di;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_rd  <= '0;
            r_out_wr  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
            if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_out_push) r_out_mem[r_out_wr] <= d_in;
    end

    // An empty-FIFO read of the head returns whatever sits at the read pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (w_rd_req) begin
            case (addr)
                A_IN_DATA:  d_out <= r_in_mem[r_in_rd];
                A_IN_STAT:  d_out <= w_in_stat;
                A_OUT_DATA: d_out <= '0;
                A_OUT_STAT: d_out <= w_out_stat;
                default:    d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
`timescale 1ns/1ps
// Self-checking bench for cardinal_nic: directed scenarios followed by random
// traffic, all compared against a queue-based model of the register map.
module tb_cardinal_nic;

    localparam int IN_DEPTH  = 2;
    localparam int OUT_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;

    cardinal_nic #(
        .DATA_W   (64),
        .IN_DEPTH (IN_DEPTH),
        .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .d_in   (d_in),
        .d_out  (d_out),
        .nicEn  (nicEn),
        .nicWrEn(nicWrEn),
        .net_si (net_si),
        .net_ri (net_ri),
        .net_di (net_di),
        .net_so (net_so),
        .net_ro (net_ro),
        .net_do (net_do)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [0:63] in_q[$];
    logic [0:63] out_q[$];
    logic [0:63] hist[$];
    int          pops;
    logic [0:63] exp_dout;
    bit          dout_known;

    task automatic check(input string tag, input logic [0:63] got, input logic [0:63] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock: update the model from the inputs now applied, then
    // compare the DUT outputs half a cycle after the edge.
    task automatic step();
        bit in_push;
        bit out_pop;
        bit out_push;
        if (reset) begin
            in_q.delete();
            out_q.delete();
            hist.delete();
            pops       = 0;
            exp_dout   = '0;
            dout_known = 1'b1;
        end else begin
            in_push  = net_si && (in_q.size() != IN_DEPTH);
            out_pop  = (out_q.size() != 0) && net_ro;
            out_push = nicEn && nicWrEn && (addr == 2'd2) && (out_q.size() != OUT_DEPTH);
            if (nicEn && !nicWrEn) begin
                dout_known = 1'b1;
                case (addr)
                    2'd0: begin
                        if (in_q.size() != 0) begin
                            exp_dout = in_q.pop_front();
                            pops++;
                        end else if (pops >= IN_DEPTH) begin
                            // Empty: the slot at the read pointer last held push number pops-DEPTH.
                            exp_dout = hist[pops - IN_DEPTH];
                        end else begin
                            dout_known = 1'b0;
                        end
                    end
                    2'd1:    exp_dout = (in_q.size() != 0) ? 64'd1 : 64'd0;
                    2'd2:    exp_dout = 64'd0;
                    default: exp_dout = (out_q.size() == OUT_DEPTH) ? 64'd1 : 64'd0;
                endcase
            end
            if (in_push) begin
                in_q.push_back(net_di);
                hist.push_back(net_di);
            end
            if (out_pop) void'(out_q.pop_front());
            if (out_push) out_q.push_back(d_in);
        end
        @(posedge clk);
        @(negedge clk);
        if (dout_known) check("d_out", d_out, exp_dout);
        check("net_so", {63'd0, net_so}, {63'd0, out_q.size() != 0});
        if (out_q.size() != 0) check("net_do", net_do, out_q[0]);
        check("net_ri", {63'd0, net_ri}, {63'd0, !reset && (in_q.size() != IN_DEPTH)});
    endtask

    task automatic drive(input logic en, input logic we, input logic [0:1] a,
                         input logic [0:63] din, input logic si, input logic [0:63] di,
                         input logic ro);
        nicEn   = en;
        nicWrEn = we;
        addr    = a;
        d_in    = din;
        net_si  = si;
        net_di  = di;
        net_ro  = ro;
        step();
    endtask

    task automatic idle(); drive(0, 0, 2'd0, '0, 0, '0, 0); endtask
    task automatic rd(input logic [0:1] a); drive(1, 0, a, '0, 0, '0, 0); endtask
    task automatic wr(input logic [0:1] a, input logic [0:63] v); drive(1, 1, a, v, 0, '0, 0); endtask

    localparam logic [0:63] PA = 64'hAAAA_0000_0000_0001;
    localparam logic [0:63] P1 = 64'h1111_2222_3333_4444;
    localparam logic [0:63] P2 = 64'h5555_6666_7777_8888;
    localparam logic [0:63] P3 = 64'h9999_AAAA_BBBB_CCCC;

    initial begin
        reset = 1'b1;
        pops = 0; exp_dout = '0; dout_known = 1'b0;
        nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0;
        net_si = 0; net_di = '0; net_ro = 0;
        @(negedge clk);
        step();
        step();
        check("ri_in_reset", {63'd0, net_ri}, 64'd0);
        reset = 1'b0;

        idle();
        check("idle_dout", d_out, 64'd0);
        check("idle_so", {63'd0, net_so}, 64'd0);
        check("idle_ri", {63'd0, net_ri}, 64'd1);
        rd(2'd1); check("idle_istat", d_out, 64'd0);
        rd(2'd3); check("idle_ostat", d_out, 64'd0);

        drive(0, 0, 2'd0, '0, 1, PA, 0);
        rd(2'd1); check("istat_one", d_out, 64'd1);
        rd(2'd0); check("head_pa", d_out, PA);
        rd(2'd1); check("istat_empty", d_out, 64'd0);

        drive(0, 0, 2'd0, '0, 1, P1, 0);
        drive(0, 0, 2'd0, '0, 1, P2, 0);
        check("ri_full", {63'd0, net_ri}, 64'd0);
        drive(0, 0, 2'd0, '0, 1, P3, 0);
        drive(1, 0, 2'd0, '0, 1, P3, 0);
        check("pop_p1", d_out, P1);
        check("ri_room", {63'd0, net_ri}, 64'd1);
        drive(0, 0, 2'd0, '0, 1, P3, 0);
        rd(2'd0); check("pop_p2", d_out, P2);
        rd(2'd0); check("pop_p3", d_out, P3);

        wr(2'd2, 64'h1);
        wr(2'd2, 64'h2);
        rd(2'd3); check("ostat_full", d_out, 64'd1);
        wr(2'd2, 64'h3);
        check("do_first", net_do, 64'h1);
        drive(0, 0, 2'd0, '0, 0, '0, 1); check("do_second", net_do, 64'h2);
        drive(0, 0, 2'd0, '0, 0, '0, 1); check("so_drained", {63'd0, net_so}, 64'd0);

        wr(2'd2, 64'h5);
        wr(2'd2, 64'h6);
        drive(1, 1, 2'd2, 64'h9, 0, '0, 1);
        check("drop9_head", net_do, 64'h6);
        drive(0, 0, 2'd0, '0, 0, '0, 1);
        check("drop9_empty", {63'd0, net_so}, 64'd0);

        drive(1, 1, 2'd2, 64'h77, 1, P1, 0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("rst_so", {63'd0, net_so}, 64'd0);
        check("rst_dout", d_out, 64'd0);
        rd(2'd1); check("rst_istat", d_out, 64'd0);
        rd(2'd3); check("rst_ostat", d_out, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  {$urandom(), $urandom()}, $urandom_range(0, 1),
                  {$urandom(), $urandom()}, ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
